sap1_prog_loader: RTL and testbench
===================================

Name: sap1_prog_loader

Overview:
Program-memory writer for the SAP-1 hardwired CPU. It accepts a 16-byte program image plus a checksum byte over a valid/ready byte stream and writes the image into an internal 16x8 RAM. The RAM has an asynchronous read port that the CPU fetch/execute path reads through its 4-bit address / 8-bit data interface. The loader holds the CPU in reset while loading and releases it only after the checksum verifies.

Parameters:
DEPTH, 16, number of program RAM words
ADDR_W, 4, RAM address width (DEPTH = 2**ADDR_W)
DATA_W, 8, RAM word and stream byte width
RST_HOLD, 2, cycles cpu_rst stays high after checksum pass, before release (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins a load (IDLE/ERROR/RUN only)
byte_in  input  DATA_W  stream data
byte_valid  input  1  byte_in valid
byte_ready  output  1  loader accepts byte this cycle
cpu_addr  input  ADDR_W  CPU read address (from MAR)
cpu_rdata  output  DATA_W  mem[cpu_addr], combinational
cpu_rst  output  1  reset to CPU, active high
done  output  1  image verified, CPU running
err  output  1  checksum mismatch on last load
load_cnt  output  ADDR_W+1  bytes of image accepted (0..16)

Behaviour:
- Handshake: a transfer occurs on a rising edge with byte_valid=1 and byte_ready=1. When byte_ready=0, byte_valid is ignored and nothing is written.
- States: IDLE, LOAD, CHECK, HOLD, RUN, ERROR. All outputs are registered except cpu_rdata.
- Reset (any state):
  - state=IDLE, cpu_rst=1, byte_ready=0, done=0, err=0, load_cnt=0.
  - Internal csum=0, hold counter=0.
  - RAM contents are not cleared.
  - Reset during a load abandons it. Words already written stay in RAM; done stays 0.
- IDLE: cpu_rst=1. start -> LOAD, with load_cnt=0 and csum=0.
- LOAD: byte_ready=1. On each transfer:
  - mem[load_cnt[ADDR_W-1:0]] <= byte_in.
  - csum <= csum + byte_in, mod 2**DATA_W.
  - load_cnt++.
  - The transfer with load_cnt==DEPTH-1 moves the state to CHECK; load_cnt then reads 16.
- CHECK: byte_ready=1; nothing is written to RAM. On transfer:
  - (csum + byte_in) mod 256 == 0 -> HOLD.
  - Otherwise -> ERROR.
- HOLD: byte_ready=0, cpu_rst=1. Stays in HOLD for exactly RST_HOLD cycles, then -> RUN.
- RUN: cpu_rst=0, done=1, byte_ready=0.
  - start -> LOAD (reload). On that edge cpu_rst returns to 1, done clears, and load_cnt and csum clear.
- ERROR: err=1, cpu_rst=1, done=0, byte_ready=0. start -> LOAD with err cleared.
- start is ignored in LOAD, CHECK and HOLD.
- byte_ready drops on the same edge that leaves CHECK. No extra byte is accepted after the checksum.
- cpu_rdata is always valid, including during a load. A read of the word being written returns the old value until the write edge.
- Latency:
  - Final image byte to CHECK: 1 edge.
  - Checksum byte to first cycle with cpu_rst=0: RST_HOLD+1 edges.

Test Plan:
- Good load. After rst, pulse start, then stream 09,1A,1B,2C,E0,F0,00,00,00,10,14,18,20,00,00,00 and checksum 6A.
  - load_cnt steps 1..16.
  - cpu_rst=0 and done=1 exactly 3 edges after the 6A transfer (RST_HOLD=2).
  - cpu_addr=0..F returns the image, e.g. addr 3 -> 2C, addr C -> 20.
- Bad checksum. Same image with checksum 6B -> err=1, cpu_rst=1, done=0. A subsequent start clears err and byte_ready rises.
- Stalls. The good image with byte_valid deasserted on alternate cycles gives the same result. With byte_valid=1 while state=IDLE: no RAM write and load_cnt stays 0.
- Reset mid-load. Assert rst after 5 bytes -> IDLE, load_cnt=0, cpu_rst=1. mem[0..4] still holds 09,1A,1B,2C,E0.
- Reload from RUN. After the good load, pulse start -> cpu_rst=1 on the next edge and done=0. Load an image of all 01 with checksum F0 -> done=1, and every address reads 01.
- Ignored start. A start pulse during LOAD, sent after 8 bytes, leaves load_cnt at 8. The load completes normally.

Source files
------------

// File: rtl/sap1_prog_loader.sv
// SAP-1 program loader: streams a 16-byte image plus checksum byte into an
// internal 16x8 program RAM and holds the CPU in reset until the image has
// been verified. The RAM read port is combinational for the CPU fetch path.
//
//  state | meaning
//  IDLE  | CPU held in reset, waiting for start
//  LOAD  | accepting image bytes into RAM, accumulating checksum
//  CHECK | accepting the checksum byte, nothing written to RAM
//  HOLD  | checksum passed, CPU reset held for RST_HOLD cycles
//  RUN   | CPU released, image verified
//  ERROR | checksum mismatch, CPU held in reset
module sap1_prog_loader #(
  parameter int ADDR_W   = 4,
  parameter int DEPTH    = 2**ADDR_W,
  parameter int DATA_W   = 8,
  parameter int RST_HOLD = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] byte_in_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_rst_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   load_cnt_o
);

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_HOLD  = 3'd3,
    S_RUN   = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  state_t              state_q;
  logic                byte_ready_q;
  logic                cpu_rst_q;
  logic                done_q;
  logic                err_q;
  logic [ADDR_W:0]     load_cnt_q;
  logic [ADDR_W:0]     load_cnt_d;
  logic [DATA_W-1:0]   csum_q;
  logic [DATA_W-1:0]   csum_d;
  logic [HOLD_W-1:0]   hold_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                xfer;

  // A transfer only happens when the loader itself advertised ready.
  assign xfer       = byte_valid_i & byte_ready_q;
  assign csum_d     = csum_q + byte_in_i;
  assign load_cnt_d = load_cnt_q + (ADDR_W+1)'(1);

  // Loader FSM with registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      byte_ready_q <= 1'b0;
      cpu_rst_q    <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      load_cnt_q   <= '0;
      csum_q       <= '0;
      hold_q       <= '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_RUN, S_ERROR: begin
          if (start_i) begin
            state_q      <= S_LOAD;
            byte_ready_q <= 1'b1;
            cpu_rst_q    <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            load_cnt_q   <= '0;
            csum_q       <= '0;
          end
        end
        S_LOAD: begin
          if (xfer) begin
            load_cnt_q <= load_cnt_d;
            csum_q     <= csum_d;
            if (load_cnt_q == (ADDR_W+1)'(DEPTH-1)) begin
              state_q <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (xfer) begin
            byte_ready_q <= 1'b0;
            if (csum_d == '0) begin
              state_q <= S_HOLD;
              hold_q  <= HOLD_W'(RST_HOLD-1);
            end else begin
              state_q <= S_ERROR;
              err_q   <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (hold_q == '0) begin
            state_q   <= S_RUN;
            cpu_rst_q <= 1'b0;
            done_q    <= 1'b1;
          end else begin
            hold_q <= hold_q - HOLD_W'(1);
          end
        end
        default: begin
          state_q      <= S_IDLE;
          byte_ready_q <= 1'b0;
          cpu_rst_q    <= 1'b1;
          done_q       <= 1'b0;
          err_q        <= 1'b0;
        end
      endcase
    end
  end

  // Program RAM write port; contents survive reset on purpose.
  always_ff @(posedge clk_i) begin
    if (!rst_i && state_q == S_LOAD && xfer) begin
      mem_q[load_cnt_q[ADDR_W-1:0]] <= byte_in_i;
    end
  end

  assign cpu_rdata_o  = mem_q[cpu_addr_i];
  assign byte_ready_o = byte_ready_q;
  assign cpu_rst_o    = cpu_rst_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign load_cnt_o   = load_cnt_q;

endmodule

// File: tb/tb_sap1_prog_loader.sv
// Directed bench for sap1_prog_loader: good/bad loads, stalls, reset during
// a load, reload from RUN and start pulses that must be ignored.
module tb_sap1_prog_loader;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic [3:0] cpu_addr;
  logic [7:0] cpu_rdata;
  logic       cpu_rst;
  logic       done;
  logic       err;
  logic [4:0] load_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] good_img [16] = '{8'h09, 8'h1A, 8'h1B, 8'h2C, 8'hE0, 8'hF0, 8'h00, 8'h00,
                                8'h00, 8'h10, 8'h14, 8'h18, 8'h20, 8'h00, 8'h00, 8'h00};

  sap1_prog_loader dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .byte_in_i    (byte_in),
    .byte_valid_i (byte_valid),
    .byte_ready_o (byte_ready),
    .cpu_addr_i   (cpu_addr),
    .cpu_rdata_o  (cpu_rdata),
    .cpu_rst_o    (cpu_rst),
    .done_o       (done),
    .err_o        (err),
    .load_cnt_o   (load_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present one byte and wait (bounded) for it to be accepted.
  task automatic send_byte(input logic [7:0] b);
    bit sent = 1'b0;
    byte_in    = b;
    byte_valid = 1'b1;
    for (int i = 0; i < 20 && !sent; i++) begin
      if (byte_ready) sent = 1'b1;
      tick();
    end
    byte_valid = 1'b0;
    n_checks++;
    if (!sent) begin
      n_fail++;
      $display("FAIL send_byte: byte %h not accepted, byte_ready=%b required 1", b, byte_ready);
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 10 && !done; i++) tick();
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_done: done=%b required 1", done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; byte_in = '0; byte_valid = 1'b0; cpu_addr = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if ({cpu_rst, byte_ready, done, err, load_cnt} !== {1'b1, 1'b0, 1'b0, 1'b0, 5'd0}) begin
      n_fail++;
      $display("FAIL reset: rst/rdy/done/err/cnt=%b%b%b%b/%0d required 1000/0",
               cpu_rst, byte_ready, done, err, load_cnt);
    end
  endtask

  task automatic test_good_load();
    pulse_start();
    n_checks++;
    if (byte_ready !== 1'b1 || load_cnt !== 5'd0) begin
      n_fail++;
      $display("FAIL good_start: byte_ready=%b load_cnt=%0d required 1/0", byte_ready, load_cnt);
    end
    for (int i = 0; i < 16; i++) begin
      send_byte(good_img[i]);
      n_checks++;
      if (load_cnt !== 5'(i + 1)) begin
        n_fail++;
        $display("FAIL good_cnt: load_cnt=%0d required %0d", load_cnt, i + 1);
      end
    end
    send_byte(8'h6A);
    n_checks++;
    if (cpu_rst !== 1'b1 || byte_ready !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL good_e0: cpu_rst=%b byte_ready=%b done=%b required 1/0/0", cpu_rst, byte_ready, done);
    end
    tick();
    n_checks++;
    if (cpu_rst !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL good_e1: cpu_rst=%b done=%b required 1/0", cpu_rst, done);
    end
    tick();
    n_checks++;
    if (cpu_rst !== 1'b0 || done !== 1'b1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL good_e2: cpu_rst=%b done=%b err=%b required 0/1/0", cpu_rst, done, err);
    end
    for (int a = 0; a < 16; a++) begin
      cpu_addr = 4'(a);
      #1;
      n_checks++;
      if (cpu_rdata !== good_img[a]) begin
        n_fail++;
        $display("FAIL good_mem: addr %h rdata=%h required %h", a, cpu_rdata, good_img[a]);
      end
    end
  endtask

  task automatic test_bad_checksum();
    pulse_start();
    n_checks++;
    if (cpu_rst !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_start: cpu_rst=%b done=%b required 1/0", cpu_rst, done);
    end
    for (int i = 0; i < 16; i++) send_byte(good_img[i]);
    send_byte(8'h6B);
    tick(); tick(); tick();
    n_checks++;
    if (err !== 1'b1 || cpu_rst !== 1'b1 || done !== 1'b0 || byte_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_err: err=%b cpu_rst=%b done=%b rdy=%b required 1/1/0/0", err, cpu_rst, done, byte_ready);
    end
    pulse_start();
    n_checks++;
    if (err !== 1'b0 || byte_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_restart: err=%b byte_ready=%b required 0/1", err, byte_ready);
    end
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic test_idle_valid();
    byte_in = 8'hAA; byte_valid = 1'b1;
    tick(); tick(); tick();
    byte_valid = 1'b0;
    cpu_addr = 4'h0;
    #1;
    n_checks++;
    if (load_cnt !== 5'd0 || byte_ready !== 1'b0 || cpu_rdata !== 8'h09) begin
      n_fail++;
      $display("FAIL idle_valid: cnt=%0d rdy=%b mem0=%h required 0/0/09", load_cnt, byte_ready, cpu_rdata);
    end
  endtask

  task automatic test_stall();
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      send_byte(good_img[i]);
      tick();
    end
    send_byte(8'h6A);
    wait_done();
    cpu_addr = 4'h3;
    #1;
    n_checks++;
    if (cpu_rst !== 1'b0 || err !== 1'b0 || load_cnt !== 5'd16 || cpu_rdata !== 8'h2C) begin
      n_fail++;
      $display("FAIL stall: cpu_rst=%b err=%b cnt=%0d mem3=%h required 0/0/16/2C", cpu_rst, err, load_cnt, cpu_rdata);
    end
  endtask

  task automatic test_reload();
    pulse_start();
    n_checks++;
    if (cpu_rst !== 1'b1 || done !== 1'b0 || load_cnt !== 5'd0 || byte_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reload_start: cpu_rst=%b done=%b cnt=%0d rdy=%b required 1/0/0/1", cpu_rst, done, load_cnt, byte_ready);
    end
    for (int i = 0; i < 16; i++) send_byte(8'h01);
    send_byte(8'hF0);
    wait_done();
    for (int a = 0; a < 16; a++) begin
      cpu_addr = 4'(a);
      #1;
      n_checks++;
      if (cpu_rdata !== 8'h01) begin
        n_fail++;
        $display("FAIL reload_mem: addr %h rdata=%h required 01", a, cpu_rdata);
      end
    end
  endtask

  task automatic test_reset_midload();
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(good_img[i]);
    n_checks++;
    if (load_cnt !== 5'd5) begin
      n_fail++;
      $display("FAIL midload_cnt: load_cnt=%0d required 5", load_cnt);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    n_checks++;
    if (load_cnt !== 5'd0 || cpu_rst !== 1'b1 || done !== 1'b0 || byte_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midload_rst: cnt=%0d cpu_rst=%b done=%b rdy=%b required 0/1/0/0", load_cnt, cpu_rst, done, byte_ready);
    end
    for (int a = 0; a < 6; a++) begin
      cpu_addr = 4'(a);
      #1;
      n_checks++;
      if (cpu_rdata !== ((a < 5) ? good_img[a] : 8'h01)) begin
        n_fail++;
        $display("FAIL midload_mem: addr %h rdata=%h required %h", a, cpu_rdata,
                 (a < 5) ? good_img[a] : 8'h01);
      end
    end
  endtask

  task automatic test_ignored_start();
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(good_img[i]);
    pulse_start();
    n_checks++;
    if (load_cnt !== 5'd8 || byte_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ign_start: load_cnt=%0d byte_ready=%b required 8/1", load_cnt, byte_ready);
    end
    for (int i = 8; i < 16; i++) send_byte(good_img[i]);
    send_byte(8'h6A);
    wait_done();
    cpu_addr = 4'hC;
    #1;
    n_checks++;
    if (cpu_rdata !== 8'h20 || err !== 1'b0 || cpu_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL ign_done: memC=%h err=%b cpu_rst=%b required 20/0/0", cpu_rdata, err, cpu_rst);
    end
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_bad_checksum();
    test_idle_valid();
    test_stall();
    test_reload();
    test_reset_midload();
    test_ignored_start();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
